// File: rtl/ipc_link_ctrl_pkg.sv
// ql_ipc_pkg: shared definitions for the host-side IPC serial link sequencer.
//   - link_state_e : sequencer FSM states
//   - DefTimeout   : default ce_11m ticks to wait for a comctrl edge
//   - DefStartLen  : default ce_11m ticks comdata_out is held low to mark a bit start
//   - MaxBits      : upper clamp for command/reply bit counts
//   - clamp_len    : bit-count clamp helper
package ql_ipc_pkg;

    localparam int unsigned DefTimeout  = 4095;
    localparam int unsigned DefStartLen = 4;
    localparam int unsigned MaxBits     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitAck,
        StData,
        StNext,
        StDone,
        StErr
    } link_state_e;

    // Clamp a requested bit count to MaxBits; with min_one a zero count becomes 1.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic min_one);
        logic [3:0] res;
        res = len;
        if (len > 4'(MaxBits)) begin
            res = 4'(MaxBits);
        end else if (min_one && (len == 4'd0)) begin
            res = 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ipc_link_ctrl_if.sv
// ipc_link_ctrl_if: request/response bus plus the IPC serial lines of ipc_link_ctrl.
//   slave  modport : the sequencer (accepts requests, drives comdata_out)
//   master modport : the requester / IPC side
//   req_valid/req_ready, tx_data[7:0], tx_len[3:0], rx_len[3:0] : transaction request
//   rsp_valid, rsp_data[7:0], rsp_err, busy                      : transaction result
//   comctrl, comdata_in, comdata_out                             : IPC serial link
interface ipc_link_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] tx_data;
    logic [3:0] tx_len;
    logic [3:0] rx_len;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       comctrl;
    logic       comdata_in;
    logic       comdata_out;

    modport slave (
        input  req_valid, tx_data, tx_len, rx_len, comctrl, comdata_in,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, comdata_out
    );

    modport master (
        output req_valid, tx_data, tx_len, rx_len, comctrl, comdata_in,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, comdata_out
    );
endinterface

// File: rtl/ipc_link_ctrl_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs.
//   i_clk    : destination clock
//   i_rst_n  : asynchronous active-low reset, loads ResetVal
//   i_d      : asynchronous input bits
//   o_q      : synchronized output (2 clk latency)
module sync2 #(
    parameter int unsigned         Width    = 1,
    parameter logic [Width-1:0]    ResetVal = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= ResetVal;
            r_sync <= ResetVal;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ipc_link_ctrl.sv
// ipc_link_ctrl: host-side sequencer for the 8049 IPC serial link (comctrl/comdata).
// One transaction at a time: 1-8 command bits MSB first, then 0-8 reply bits.
// Each bit: comdata_out low for START_LEN ticks, wait for comctrl falling (ack),
// present/release data, finish on comctrl rising. Any wait longer than TIMEOUT
// ce_11m ticks aborts with rsp_err.
//   clk, reset_n : system clock, asynchronous active-low reset
//   ce_11m       : tick enable for all timing counters
//   bus          : request/response handshake and IPC serial lines (slave modport)
module ipc_link_ctrl
    import ql_ipc_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DefTimeout,
    parameter int unsigned START_LEN = DefStartLen
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_11m,
    ipc_link_ctrl_if.slave     bus
);

    localparam logic [11:0] TimeoutLast = 12'(TIMEOUT - 1);
    localparam logic [11:0] StartLast   = 12'(START_LEN - 1);

    logic        w_comctrl_s;
    logic        w_comdata_s;
    logic        w_ctrl_fall;
    logic        w_ctrl_rise;
    logic        w_accept;
    logic [3:0]  w_tx_len_c;
    logic [3:0]  w_rx_len_c;

    link_state_e r_state;
    logic        r_comctrl_prev;
    logic [11:0] r_tick_cnt;
    logic [7:0]  r_tx_shift;
    logic [3:0]  r_tx_left;
    logic [3:0]  r_rx_left;
    logic        r_rx_phase;
    logic [7:0]  r_rsp_data;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_comdata_out;

    // Lines idle high, so reset the synchronizers high to avoid a phantom falling edge.
    sync2 #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync_comctrl (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (bus.comctrl),
        .o_q     (w_comctrl_s)
    );

    sync2 #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync_comdata (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (bus.comdata_in),
        .o_q     (w_comdata_s)
    );

    assign w_ctrl_fall = r_comctrl_prev & ~w_comctrl_s;
    assign w_ctrl_rise = ~r_comctrl_prev & w_comctrl_s;
    assign w_accept    = bus.req_valid & r_req_ready;
    assign w_tx_len_c  = clamp_len(bus.tx_len, 1'b1);
    assign w_rx_len_c  = clamp_len(bus.rx_len, 1'b0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_comctrl_prev <= 1'b1;
            r_tick_cnt     <= '0;
            r_tx_shift     <= '0;
            r_tx_left      <= '0;
            r_rx_left      <= '0;
            r_rx_phase     <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_comdata_out  <= 1'b1;
        end else begin
            r_comctrl_prev <= w_comctrl_s;
            r_rsp_valid    <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state       <= StStart;
                        r_req_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_tx_shift    <= bus.tx_data;
                        r_tx_left     <= w_tx_len_c;
                        r_rx_left     <= w_rx_len_c;
                        r_rx_phase    <= 1'b0;
                        r_rsp_data    <= '0;
                        r_rsp_err     <= 1'b0;
                        r_tick_cnt    <= '0;
                        r_comdata_out <= 1'b0;
                    end
                end

                StStart: begin
                    if (ce_11m) begin
                        if (r_tick_cnt == StartLast) begin
                            r_state    <= StWaitAck;
                            r_tick_cnt <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 12'd1;
                        end
                    end
                end

                StWaitAck: begin
                    // Edge is checked first so it wins over a coincident expiry.
                    if (w_ctrl_fall) begin
                        r_state       <= StData;
                        r_tick_cnt    <= '0;
                        r_comdata_out <= r_rx_phase ? 1'b1 : r_tx_shift[7];
                    end else if (ce_11m) begin
                        if (r_tick_cnt == TimeoutLast) begin
                            r_state       <= StErr;
                            r_comdata_out <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 12'd1;
                        end
                    end
                end

                StData: begin
                    if (w_ctrl_rise) begin
                        r_state       <= StNext;
                        r_comdata_out <= 1'b1;
                        if (r_rx_phase) begin
                            r_rsp_data <= {r_rsp_data[6:0], w_comdata_s};
                        end
                    end else if (ce_11m) begin
                        if (r_tick_cnt == TimeoutLast) begin
                            r_state       <= StErr;
                            r_comdata_out <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 12'd1;
                        end
                    end
                end

                StNext: begin
                    r_comdata_out <= 1'b1;
                    r_tick_cnt    <= '0;
                    if (!r_rx_phase) begin
                        r_tx_left  <= r_tx_left - 4'd1;
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        if (r_tx_left == 4'd1) begin
                            if (r_rx_left != 4'd0) begin
                                r_rx_phase    <= 1'b1;
                                r_state       <= StStart;
                                r_comdata_out <= 1'b0;
                            end else begin
                                r_state     <= StDone;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                            end
                        end else begin
                            r_state       <= StStart;
                            r_comdata_out <= 1'b0;
                        end
                    end else begin
                        r_rx_left <= r_rx_left - 4'd1;
                        if (r_rx_left == 4'd1) begin
                            r_state     <= StDone;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state       <= StStart;
                            r_comdata_out <= 1'b0;
                        end
                    end
                end

                StDone, StErr: begin
                    // rsp_valid was raised on entry; it drops as we return to idle.
                    r_state       <= StIdle;
                    r_req_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_comdata_out <= 1'b1;
                    r_tick_cnt    <= '0;
                end

                default: begin
                    r_state       <= StIdle;
                    r_req_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_comdata_out <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.busy        = r_busy;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.comdata_out = r_comdata_out;

endmodule

// File: tb/tb_ipc_link_ctrl.sv
// Self-checking bench for ipc_link_ctrl with a behavioural IPC model and a
// response scoreboard.
`timescale 1ns/1ps
module tb_ipc_link_ctrl;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce_11m  = 1'b0;

    ipc_link_ctrl_if bus_if ();

    ipc_link_ctrl #(
        .TIMEOUT   (4095),
        .START_LEN (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_11m  (ce_11m),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ce_11m = ~ce_11m;
        end
    end

    int ticks = 0;
    always @(posedge clk) if (ce_11m) ticks <= ticks + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t exp_rsp_q[$];
    logic exp_tx_q[$];

    // Response monitor / scoreboard
    logic prev_rsp_valid = 1'b0;
    int   rsp_cnt  = 0;
    int   rsp_tick = 0;
    always @(negedge clk) begin
        if (bus_if.rsp_valid) begin
            rsp_t e;
            check_eq("rsp_pulse_width", 32'(prev_rsp_valid), 0);
            check_eq("rsp_expected", 32'(exp_rsp_q.size() != 0), 1);
            if (exp_rsp_q.size() != 0) begin
                e = exp_rsp_q.pop_front();
                check_eq("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
                check_eq("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
            end
            rsp_cnt++;
            rsp_tick = ticks;
        end
        prev_rsp_valid = bus_if.rsp_valid;
    end

    task automatic wait_ticks(input int n);
        int t0;
        t0 = ticks;
        while (ticks - t0 < n) @(negedge clk);
    endtask

    // IPC model: acks each bit start, captures TX bits, supplies reply bits.
    bit         m_en = 1'b0;
    int         m_ntx = 0;
    int         m_nrx = 0;
    int         m_idx = 0;
    logic [7:0] m_reply = 8'h00;

    initial begin
        bus_if.comctrl    = 1'b1;
        bus_if.comdata_in = 1'b1;
        forever begin
            @(negedge clk);
            if (m_en && (bus_if.comdata_out === 1'b0)) begin
                int b;
                int k;
                logic e;
                wait_ticks(10);
                bus_if.comctrl = 1'b0;
                wait_ticks(10);
                check_eq("bit_in_range", 32'(m_idx < m_ntx + m_nrx), 1);
                if (m_idx < m_ntx) begin
                    e = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 1'bx;
                    check_eq("tx_bit", 32'(bus_if.comdata_out), 32'(e));
                end else begin
                    k = m_nrx - 1 - (m_idx - m_ntx);
                    check_eq("rx_released", 32'(bus_if.comdata_out), 1);
                    bus_if.comdata_in = (k >= 0) ? m_reply[k[2:0]] : 1'b0;
                end
                wait_ticks(4);
                bus_if.comctrl = 1'b1;
                m_idx++;
                b = 0;
                while (bus_if.comdata_out !== 1'b1 && b < 60) begin
                    @(negedge clk);
                    b++;
                end
                check_eq("bit_release", 32'(bus_if.comdata_out), 1);
            end
        end
    end

    int t_acc = 0;

    task automatic issue_req(input logic [7:0] td, input logic [3:0] tl, input logic [3:0] rl);
        @(negedge clk);
        check_eq("req_ready_idle", 32'(bus_if.req_ready), 1);
        bus_if.tx_data   = td;
        bus_if.tx_len    = tl;
        bus_if.rx_len    = rl;
        bus_if.req_valid = 1'b1;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        t_acc = ticks;
    endtask

    task automatic wait_rsp(input int n0, input int budget);
        int b;
        b = budget;
        while (rsp_cnt == n0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check_eq("rsp_arrived", 32'(rsp_cnt - n0), 1);
    endtask

    task automatic do_txn(input logic [7:0] td, input logic [3:0] tl, input logic [3:0] rl,
                          input logic [7:0] reply, input bit poke);
        int         ntx;
        int         nrx;
        int         n0;
        logic [8:0] m9;
        rsp_t       r;
        ntx = (tl == 0) ? 1 : ((tl > 8) ? 8 : int'(tl));
        nrx = (rl > 8) ? 8 : int'(rl);
        for (int i = 0; i < ntx; i++) exp_tx_q.push_back(td[7-i]);
        m9 = (9'd1 << nrx) - 9'd1;
        r.data = reply & m9[7:0];
        r.err  = 1'b0;
        exp_rsp_q.push_back(r);
        m_ntx = ntx; m_nrx = nrx; m_reply = reply; m_idx = 0; m_en = 1'b1;
        n0 = rsp_cnt;
        issue_req(td, tl, rl);
        if (poke) begin
            repeat (6) @(negedge clk);
            bus_if.tx_data   = ~td;
            bus_if.req_valid = 1'b1;
            @(negedge clk);
            bus_if.req_valid = 1'b0;
        end
        wait_rsp(n0, 3000);
        repeat (40) @(negedge clk);
        check_eq("bits_used", 32'(m_idx), 32'(ntx + nrx));
        check_eq("tx_bits_left", 32'(exp_tx_q.size()), 0);
        check_eq("single_rsp", 32'(rsp_cnt - n0), 1);
        check_eq("idle_busy", 32'(bus_if.busy), 0);
        check_eq("idle_comdata", 32'(bus_if.comdata_out), 1);
        m_en = 1'b0;
        exp_tx_q.delete();
    endtask

    initial begin
        int   n0;
        rsp_t r;
        bus_if.req_valid = 1'b0;
        bus_if.tx_data   = 8'h00;
        bus_if.tx_len    = 4'd0;
        bus_if.rx_len    = 4'd0;

        // 1: reset state, then reset during START
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_req_ready", 32'(bus_if.req_ready), 1);
        check_eq("rst_busy", 32'(bus_if.busy), 0);
        check_eq("rst_comdata", 32'(bus_if.comdata_out), 1);
        check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
        check_eq("rst_rsp_data", 32'(bus_if.rsp_data), 0);
        check_eq("rst_rsp_err", 32'(bus_if.rsp_err), 0);
        issue_req(8'hFF, 4'd8, 4'd0);
        repeat (2) @(negedge clk);
        check_eq("start_low", 32'(bus_if.comdata_out), 0);
        check_eq("start_busy", 32'(bus_if.busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_comdata", 32'(bus_if.comdata_out), 1);
        check_eq("abort_busy", 32'(bus_if.busy), 0);
        check_eq("abort_ready", 32'(bus_if.req_ready), 1);
        n0 = rsp_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_no_rsp", 32'(rsp_cnt - n0), 0);

        // 2: 4 command bits, no reply
        do_txn(8'hA0, 4'd4, 4'd0, 8'h00, 1'b0);
        // 3: 4 command bits, 8 reply bits
        do_txn(8'h10, 4'd4, 4'd8, 8'h5C, 1'b0);
        do_txn(8'h6B, 4'd3, 4'd5, 8'h15, 1'b0);

        // 4: IPC never acks -> timeout
        m_en   = 1'b0;
        r.data = 8'h00;
        r.err  = 1'b1;
        exp_rsp_q.push_back(r);
        n0 = rsp_cnt;
        issue_req(8'hA0, 4'd4, 4'd0);
        wait_rsp(n0, 10000);
        check_eq("timeout_ticks", 32'(rsp_tick - t_acc), 4099);
        @(negedge clk);
        check_eq("timeout_comdata", 32'(bus_if.comdata_out), 1);
        check_eq("timeout_ready", 32'(bus_if.req_ready), 1);
        check_eq("timeout_busy", 32'(bus_if.busy), 0);

        // 5: length clamps, request while busy ignored
        do_txn(8'h80, 4'd0, 4'd0, 8'h00, 1'b0);
        do_txn(8'hC5, 4'd15, 4'd15, 8'h3A, 1'b1);

        // 6: spurious comctrl activity
        m_en = 1'b0;
        bus_if.comctrl = 1'b0;
        wait_ticks(10);
        bus_if.comctrl = 1'b1;
        wait_ticks(10);
        check_eq("spur_idle_busy", 32'(bus_if.busy), 0);
        check_eq("spur_idle_comdata", 32'(bus_if.comdata_out), 1);
        r.data = 8'h00;
        r.err  = 1'b0;
        exp_rsp_q.push_back(r);
        n0 = rsp_cnt;
        issue_req(8'h80, 4'd1, 4'd0);
        bus_if.comctrl = 1'b0;
        wait_ticks(12);
        bus_if.comctrl = 1'b1;
        wait_ticks(6);
        check_eq("spur_wait_ack_hold", 32'(bus_if.comdata_out), 0);
        check_eq("spur_wait_ack_busy", 32'(bus_if.busy), 1);
        bus_if.comctrl = 1'b0;
        wait_ticks(10);
        check_eq("spur_bit", 32'(bus_if.comdata_out), 1);
        bus_if.comctrl = 1'b1;
        wait_rsp(n0, 500);
        repeat (10) @(negedge clk);
        check_eq("spur_done_busy", 32'(bus_if.busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
